// File: rtl/progmem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : progmem_loader_if
// Description : Byte-stream input and program-memory write port of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface progmem_loader_if;
    logic [7:0]  i_byte;
    logic        i_byte_valid;
    logic        o_byte_ready;
    logic        o_we;
    logic [7:0]  o_addr;
    logic [39:0] o_data;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport slave (
        input  i_byte,
        input  i_byte_valid,
        output o_byte_ready,
        output o_we,
        output o_addr,
        output o_data
    );

    // Stream source / memory side.
    modport master (
        output i_byte,
        output i_byte_valid,
        input  o_byte_ready,
        input  o_we,
        input  o_addr,
        input  o_data
    );
endinterface
`default_nettype wire

// File: rtl/progmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : progmem_loader
// Description : Writes a framed, XOR-checksummed byte stream of 40-bit words
//               into program memory and gates CPU execution on success.
// Revision    : 1.0 - initial release
// ============================================================================
module progmem_loader #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    progmem_loader_if.slave bus,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_error,
    output logic            o_cpu_run
);

    // Counter only has to reach TIMEOUT_CYCLES-1; the hit is decoded there.
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_DATA = 3'd2;
    localparam logic [2:0] c_ST_CSUM = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;
    localparam logic [2:0] c_ST_ERR  = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_busy;
    logic               w_busy_nxt;

    logic [2:0]         r_byte_idx;
    logic [7:0]         r_word_idx;
    logic [7:0]         r_last_idx;
    logic [7:0]         r_acc;
    logic [31:0]        r_shift;
    logic [c_TMO_W-1:0] r_tmo;

    logic               r_we;
    logic [7:0]         r_addr;
    logic [39:0]        r_data;
    logic               r_done;
    logic               r_error;
    logic               r_cpu_run;

    logic               w_accept;
    logic               w_tmo_hit;
    logic               w_last_byte;
    logic               w_last_word;
    logic               w_csum_ok;
    logic               w_start;

    assign w_accept    = bus.i_byte_valid && r_busy;
    assign w_tmo_hit   = !w_accept && (r_tmo == c_TMO_LAST);
    assign w_last_byte = (r_byte_idx == 3'd4);
    assign w_last_word = (r_word_idx == r_last_idx);
    assign w_csum_ok   = (bus.i_byte == r_acc);
    assign w_start     = i_start && ((r_state == c_ST_IDLE) ||
                                     (r_state == c_ST_DONE) ||
                                     (r_state == c_ST_ERR));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (i_start) w_state_nxt = c_ST_HDR;
            end
            c_ST_HDR: begin
                if (w_accept)       w_state_nxt = c_ST_DATA;
                else if (w_tmo_hit) w_state_nxt = c_ST_ERR;
            end
            c_ST_DATA: begin
                if (w_accept) begin
                    if (w_last_byte && w_last_word) w_state_nxt = c_ST_CSUM;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_ST_ERR;
                end
            end
            c_ST_CSUM: begin
                if (w_accept)       w_state_nxt = w_csum_ok ? c_ST_DONE : c_ST_ERR;
                else if (w_tmo_hit) w_state_nxt = c_ST_ERR;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign w_busy_nxt = (w_state_nxt == c_ST_HDR) ||
                        (w_state_nxt == c_ST_DATA) ||
                        (w_state_nxt == c_ST_CSUM);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_last_idx <= '0;
            r_acc      <= '0;
            r_shift    <= '0;
            r_tmo      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_run  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start) begin
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_acc      <= '0;
                r_tmo      <= '0;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
                r_cpu_run  <= 1'b0;
            end else if (r_busy) begin
                if (w_accept) r_tmo <= '0;
                else          r_tmo <= r_tmo + 1'b1;

                if (w_tmo_hit) r_error <= 1'b0 | 1'b1;

                if (w_accept) begin
                    case (r_state)
                        c_ST_HDR: begin
                            // A count byte of 0 wraps to 255, i.e. 256 words.
                            r_acc      <= bus.i_byte;
                            r_last_idx <= bus.i_byte - 8'd1;
                        end
                        c_ST_DATA: begin
                            r_acc   <= r_acc ^ bus.i_byte;
                            r_shift <= {r_shift[23:0], bus.i_byte};
                            if (w_last_byte) begin
                                r_we       <= 1'b1;
                                r_addr     <= r_word_idx;
                                r_data     <= {r_shift, bus.i_byte};
                                r_byte_idx <= '0;
                                if (!w_last_word) r_word_idx <= r_word_idx + 8'd1;
                            end else begin
                                r_byte_idx <= r_byte_idx + 3'd1;
                            end
                        end
                        c_ST_CSUM: begin
                            if (w_csum_ok) begin
                                r_done    <= 1'b1;
                                r_cpu_run <= 1'b1;
                            end else begin
                                r_error   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.o_byte_ready = r_busy;
    assign bus.o_we         = r_we;
    assign bus.o_addr       = r_addr;
    assign bus.o_data       = r_data;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_cpu_run        = r_cpu_run;

endmodule
`default_nettype wire

// File: tb/tb_progmem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_progmem_loader
// Description : Directed self-checking bench for progmem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_progmem_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, error, cpu_run;

    progmem_loader_if bus();

    progmem_loader #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_error   (error),
        .o_cpu_run (cpu_run)
    );

    always #5 clk = ~clk;

    int vectors   = 0;
    int errs      = 0;
    int we_double = 0;
    logic prev_we = 1'b0;

    logic [7:0]  wr_addr[$];
    logic [39:0] wr_data[$];
    logic [7:0]  frame[$];
    logic [39:0] exp_w[$];

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.o_we === 1'b1) begin
            if (prev_we) we_double++;
            wr_addr.push_back(bus.o_addr);
            wr_data.push_back(bus.o_data);
        end
        prev_we = (bus.o_we === 1'b1);
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        wr_addr.delete();
        wr_data.delete();
        frame.delete();
        exp_w.delete();
    endtask

    task automatic add_word(input logic [39:0] w);
        for (int b = 4; b >= 0; b--) frame.push_back(w[b*8 +: 8]);
        exp_w.push_back(w);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.i_byte       = b;
        bus.i_byte_valid = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = (bus.o_byte_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        bus.i_byte_valid = 1'b0;
        assert (ok) else begin
            errs++;
            $error("FAIL byte_accept: observed no acceptance of %0h expected acceptance", b);
        end
    endtask

    task automatic send_range(input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++)
            send_byte(frame[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic chk_writes(input string tag);
        int n;
        chk({tag, "_count"}, 40'(wr_addr.size()), 40'(exp_w.size()));
        n = (wr_addr.size() < exp_w.size()) ? wr_addr.size() : exp_w.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr[%0d]", tag, i), 40'(wr_addr[i]), 40'(i));
            chk($sformatf("%s_data[%0d]", tag, i), wr_data[i], exp_w[i]);
        end
    endtask

    task automatic build_two_word(input logic [7:0] cks);
        clear_all();
        frame.push_back(8'h02);
        add_word(40'h80_0000_0120);
        add_word(40'h00_0000_0521);
        frame.push_back(cks);
    endtask

    initial begin
        #2_000_000;
        errs++;
        $display("FAIL watchdog: observed no completion expected $finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_byte       = 8'h00;
        bus.i_byte_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   bus.o_byte_ready, 0);
        chk("rst_we",      bus.o_we, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_done",    done, 0);
        chk("rst_error",   error, 0);
        chk("rst_cpu_run", cpu_run, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two-word load; XOR of 02 and the ten data bytes is 0x87
        build_two_word(8'h87);
        do_start();
        chk("t1_busy_rise",  busy, 1);
        chk("t1_ready_rise", bus.o_byte_ready, 1);
        send_range(0, frame.size() - 1, 0);
        chk("t1_done",    done, 1);
        chk("t1_cpu_run", cpu_run, 1);
        chk("t1_error",   error, 0);
        chk("t1_busy",    busy, 0);
        chk_writes("t1");

        // Restart from DONE with a one-word frame (cks 01^AA^BB^CC^DD^EE = EF)
        clear_all();
        frame.push_back(8'h01);
        add_word(40'hAA_BBCC_DDEE);
        frame.push_back(8'hEF);
        do_start();
        chk("rs_cpu_run_drop", cpu_run, 0);
        chk("rs_done_drop",    done, 0);
        chk("rs_busy",         busy, 1);
        send_range(0, frame.size() - 2, 0);
        chk("rs_cpu_run_pre",  cpu_run, 0);
        send_range(frame.size() - 1, frame.size() - 1, 0);
        chk("rs_cpu_run_post", cpu_run, 1);
        chk("rs_done",         done, 1);
        chk_writes("rs");

        // Bad checksum
        build_two_word(8'hA6);
        do_start();
        send_range(0, frame.size() - 1, 0);
        chk("t2_error",   error, 1);
        chk("t2_done",    done, 0);
        chk("t2_cpu_run", cpu_run, 0);
        chk_writes("t2");

        // Random gaps below the timeout
        build_two_word(8'h87);
        do_start();
        send_range(0, frame.size() - 1, 12);
        chk("gap_done",  done, 1);
        chk("gap_error", error, 0);
        chk_writes("gap");

        // 256-word frame: five full 0..255 passes cancel, so checksum 0x00
        clear_all();
        frame.push_back(8'h00);
        for (int w = 0; w < 256; w++) begin
            logic [39:0] word;
            for (int b = 0; b < 5; b++) word[(4-b)*8 +: 8] = 8'((w*5 + b) % 256);
            add_word(word);
        end
        frame.push_back(8'h00);
        do_start();
        send_range(0, frame.size() - 1, 0);
        chk("full_done", done, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("full_done_hold", done, 1);
        chk_writes("full");

        // Timeout: 16 idle cycles after byte 3 of word 0
        clear_all();
        do_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_error_15", error, 0);
        chk("tmo_busy_15",  busy, 1);
        @(posedge clk);
        #1;
        chk("tmo_error_16", error, 1);
        chk("tmo_busy_16",  busy, 0);
        chk("tmo_ready",    bus.o_byte_ready, 0);
        chk("tmo_cpu_run",  cpu_run, 0);
        chk("tmo_done",     done, 0);
        chk_writes("tmo");

        // Reset pulsed after byte 2 of word 1
        clear_all();
        frame.push_back(8'h02);
        add_word(40'h11_2233_4455);
        frame.push_back(8'h66);
        frame.push_back(8'h77);
        frame.push_back(8'h88);
        do_start();
        send_range(0, frame.size() - 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_we",      bus.o_we, 0);
        chk("mr_addr",    bus.o_addr, 0);
        chk("mr_data",    bus.o_data, 0);
        chk("mr_ready",   bus.o_byte_ready, 0);
        chk("mr_busy",    busy, 0);
        chk("mr_done",    done, 0);
        chk("mr_error",   error, 0);
        chk("mr_cpu_run", cpu_run, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_byte       = 8'h99;
        bus.i_byte_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("mr_ready_idle", bus.o_byte_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.i_byte_valid = 1'b0;
        chk("mr_busy_idle", busy, 0);
        chk_writes("mr");

        // Recovery load after reset (cks 01^01^02^03^04^05 = 00)
        clear_all();
        frame.push_back(8'h01);
        add_word(40'h01_0203_0405);
        frame.push_back(8'h00);
        do_start();
        send_range(0, frame.size() - 1, 0);
        chk("rec_done",    done, 1);
        chk("rec_cpu_run", cpu_run, 1);
        chk_writes("rec");

        chk("we_single_cycle", 40'(we_double), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
